// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Queues dispense events from the vending FSM together with
//                their change amount. Each event runs one product-motor
//                handshake and then pays the change greedily as 2-cent coins
//                followed by at most one 1-cent coin. Each coin uses its own
//                ejector handshake.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                d, r            - dispense pulse and change owed (0..7)
//                vend_req/ack    - product-motor handshake
//                coin2_req/coin1_req/coin_ack - coin ejector handshake
//                busy, full, overflow, count   - status
//  Revision    : 1.0  initial release
// ============================================================================
module change_dispenser #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d,
    input  logic [2:0]                 r,
    output logic                       vend_req,
    input  logic                       vend_ack,
    output logic                       coin2_req,
    output logic                       coin1_req,
    input  logic                       coin_ack,
    output logic                       busy,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VEND = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         remaining_q;
    logic [2:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q;

    logic               pop_w;
    logic               push_w;
    logic               drop_w;
    logic [2:0]         pay_dec_w;
    logic [2:0]         rem_after_w;

    // FIFO bookkeeping. A full FIFO still accepts a push when the head is
    // popped on the same edge; an empty FIFO never pops, so a push into an
    // empty FIFO is always held for at least one cycle.
    always_comb begin
        pop_w    = (state_q == S_IDLE) && (count_q != '0);
        push_w   = d && ((count_q != C_DEPTH) || pop_w);
        drop_w   = d && !push_w;
        wr_ptr_d = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Greedy payout: a 2-cent coin whenever at least 2 remain.
        pay_dec_w   = (remaining_q >= 3'd2) ? 3'd2 : 3'd1;
        rem_after_w = remaining_q - pay_dec_w;
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push_w) begin
            mem_q[wr_ptr_q] <= r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | drop_w;
            case (state_q)
                S_IDLE: begin
                    if (pop_w) begin
                        remaining_q <= mem_q[rd_ptr_q];
                        state_q     <= S_VEND;
                    end
                end
                S_VEND: begin
                    if (vend_ack) begin
                        state_q <= (remaining_q == 3'd0) ? S_IDLE : S_PAY;
                    end
                end
                S_PAY: begin
                    if (coin_ack) begin
                        remaining_q <= rem_after_w;
                        if (rem_after_w == 3'd0) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so none of them follows an input
    // combinationally.
    assign vend_req  = (state_q == S_VEND);
    assign coin2_req = (state_q == S_PAY) && (remaining_q >= 3'd2);
    assign coin1_req = (state_q == S_PAY) && (remaining_q == 3'd1);
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign full      = (count_q == C_DEPTH);
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Downstream consumer of the vending FSM's `d`/`r` outputs. It queues each dispense event together with its change amount, drives the product-motor handshake, and then pays the change as 2-cent and 1-cent coin ejections, one ejector handshake per coin. A small request FIFO absorbs back-to-back vends, so the vending FSM never stalls.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `d`  in  1  dispense pulse from the vending FSM; one cycle per vend.
- `r`  in  3  change owed in cents (0–7); valid only when `d`=1.
- `vend_req`  out  1  product-motor request.
- `vend_ack`  in  1  product-motor done.
- `coin2_req`  out  1  eject one 2-cent coin.
- `coin1_req`  out  1  eject one 1-cent coin.
- `coin_ack`  in  1  ejector done, for whichever coin is requested.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `full`  out  1  FIFO count equals `DEPTH`.
- `overflow`  out  1  sticky; a vend was dropped.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Push:** on an edge with `d`=1, `r` is written to the FIFO if count<`DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the entry is dropped and `overflow` is set. It stays set until reset.
- **Pop:** happens only in IDLE with count>0. The head entry moves into a 3-bit `remaining` register.
- **Simultaneous push and pop:** count is unchanged. When the FIFO is empty, a push is never popped on the same edge.
- **Pointers:** wrap modulo `DEPTH`. FIFO order is strict; entries are never reordered or merged.
- **FSM states** are IDLE, VEND and PAY. All outputs are registered or decoded from state and `remaining` only (Moore); none depends combinationally on inputs.
- **IDLE:** all requests are low. If count>0, the FSM pops and goes to VEND.
- **VEND:** `vend_req`=1.
  - On an edge with `vend_ack`=1: if `remaining`=0, go to IDLE; else go to PAY.
- **PAY:** `coin2_req` = (`remaining`≥2) and `coin1_req` = (`remaining`=1). Exactly one of the two is high.
  - On an edge with `coin_ack`=1, `remaining` is decremented by 2 or 1 respectively.
  - If the result is 0, go to IDLE; otherwise stay in PAY.
- **Acks outside their state:** `vend_ack` outside VEND and `coin_ack` outside PAY are ignored.
- **Coin sequence:** greedy, with 2s before the 1.
  - r=7 gives 2,2,2,1 (4 ejections).
  - r=1 gives a single 1.
  - r=0 gives no PAY visit.
- **Reset values:** state=IDLE, FIFO empty (count=0, pointers 0), `remaining`=0, `overflow`=0.
  - All outputs are 0 after the reset edge: `vend_req`, `coin2_req`, `coin1_req`, `busy`, `full`, `overflow`, `count`.
- **Reset mid-operation:** the transaction in progress and all queued entries are discarded. Requests drop on the reset edge, with no completion of partial change. A `d` on the reset edge is ignored.

## Timing
- **Vend latency:** `d` sampled at edge N means count increments after N, the pop happens at N+1, and `vend_req` is high from N+1.
  - Minimum `d`-to-`vend_req` latency is 1 cycle when idle and empty.
- **Request hold:** a request stays high until the edge that samples its ack, and falls (or changes coin) on that same edge.
  - A zero-wait ack (ack high in the first request cycle) completes in 1 cycle.
- **Minimum transaction length:** 1 (IDLE/pop) + 1 (VEND) + k (PAY) cycles, where k is the number of coins. The next pop can occur in the IDLE cycle that follows.
- **Status outputs:** `full`, `count` and `busy` reflect register state after each edge.
- **Overflow:** `overflow` rises on the edge that drops the entry.

## Test plan
- **Basic vend:** reset, then `d`=1 with `r`=0 for 1 cycle; `vend_ack` held at 1.
  - Expect `vend_req` high for exactly 1 cycle, 1 cycle after `d`, with no coin requests.
  - Then `busy`=0 and `count`=0.
- **Overpay change:** `d` with `r`=1 (the 2+2+2 overpay case); the motor acks after 3 cycles and the ejector after 2.
  - Expect `vend_req` high for 3 cycles, then `coin1_req` high for 2 cycles, with `coin2_req` never high.
- **Greedy payout:** `r`=7, acks tied high.
  - Expect the `coin2_req` pulses 1,1,1 followed by `coin1_req` pulse 1, in consecutive cycles, then IDLE.
- **Queue and overflow:** with `vend_ack` held 0 and `DEPTH`=4, pulse `d` 6 times.
  - The first is popped and the next 4 fill the FIFO, so `full`=1.
  - The 6th is dropped and sets `overflow`=1.
  - After releasing acks, exactly 5 vends complete in order, with `r` values matching the push order.
- **Full with simultaneous push and pop:** FIFO full, and `d` arrives on the same edge as the IDLE pop.
  - Expect the push accepted, count to stay 4, and `overflow` to stay 0.
- **Reset mid-operation:** assert `reset` for 1 cycle during PAY of `r`=5 with 2 entries queued.
  - Expect all requests 0 and `count`=0 on the next cycle, `overflow` cleared, and no further requests.
